// File: rtl/encrypt_arbiter.sv
`timescale 1ns/1ps
// encrypt_arbiter
// Round-robin front end that lets N_REQ independent requesters share a
// single encrypt_iter core. One requester is served at a time: its operands
// are latched at grant, one complete 4-phase transaction is run on the core,
// and the captured ciphertext is then returned on that requester's ack.
//
// Handshake semantics (both the requester ports and the core port are
// 4-phase req/ack):
//   req rises with stable operands -> ack rises with a valid result ->
//   req falls -> ack falls. A new req may only rise after ack has fallen.
//   The arbiter samples requester operands only at grant time. On the core
//   side it holds core_req high until core_ack, drops it, and then waits for
//   core_ack to fall before ending the transaction. A core_ack that is high
//   while the arbiter is idle is treated as stale and blocks new grants.
module encrypt_arbiter #(
  parameter int N_REQ = 2,
  parameter int N_K   = 64,
  parameter int N_B   = 64,
  localparam int IW   = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_in,
  input  logic [N_REQ*N_K-1:0] k_in,
  input  logic [N_REQ*N_B-1:0] m_in,
  output logic [N_REQ-1:0]     ack_out,
  output logic [N_B-1:0]       c_out,
  output logic                 busy,
  output logic [IW-1:0]        grant,
  output logic [N_K-1:0]       core_k,
  output logic [N_B-1:0]       core_m,
  output logic                 core_req,
  input  logic [N_B-1:0]       core_c,
  input  logic                 core_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [IW-1:0]    grant_n;
  logic [N_K-1:0]   core_k_n;
  logic [N_B-1:0]   core_m_n;
  logic             core_req_n;
  logic [N_B-1:0]   c_out_n;
  logic [N_REQ-1:0] ack_out_n;

  logic [N_REQ-1:0] pending;
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW:0]      cand;

  // Round-robin search: first pending requester at or after ptr, wrapping.
  always_comb begin
    pending   = req_in & ~ack_out;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int j = 0; j < N_REQ; j++) begin
      cand = {1'b0, ptr} + (IW+1)'(j);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!win_found && pending[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // Next-state and next-register values for the service sequence.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    grant_n    = grant;
    core_k_n   = core_k;
    core_m_n   = core_m;
    core_req_n = core_req;
    c_out_n    = c_out;
    ack_out_n  = ack_out;
    case (state)
      IDLE: begin
        // A stale core_ack must clear before the core can take a new request.
        if (win_found && !core_ack) begin
          grant_n    = win_idx;
          core_k_n   = k_in[win_idx*N_K +: N_K];
          core_m_n   = m_in[win_idx*N_B +: N_B];
          core_req_n = 1'b1;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        if (core_ack) begin
          c_out_n    = core_c;
          core_req_n = 1'b0;
          state_n    = RELEASE;
        end
      end
      RELEASE: begin
        // The core's ack trails req-fall, so the round closes only once it drops.
        if (!core_ack) begin
          ack_out_n[grant] = req_in[grant];
          ptr_n            = (grant == IW'(N_REQ - 1)) ? '0 : grant + 1'b1;
          state_n          = req_in[grant] ? RESPOND : IDLE;
        end
      end
      RESPOND: begin
        if (!req_in[grant]) begin
          ack_out_n = '0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      grant    <= '0;
      core_k   <= '0;
      core_m   <= '0;
      core_req <= 1'b0;
      c_out    <= '0;
      ack_out  <= '0;
    end else begin
      ptr      <= ptr_n;
      grant    <= grant_n;
      core_k   <= core_k_n;
      core_m   <= core_m_n;
      core_req <= core_req_n;
      c_out    <= c_out_n;
      ack_out  <= ack_out_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_encrypt_arbiter.sv
`timescale 1ns/1ps
// Bench for encrypt_arbiter with two requesters and a behavioural stand-in
// for the encrypt_iter core. The stand-in computes a keyed mixing function
// instead of DES; the arbiter only routes operands and results, so the
// expected ciphertext for each request is that same function of the
// requester's own operands.
module tb_encrypt_arbiter;

  localparam int N_REQ = 2;
  localparam int N_K   = 64;
  localparam int N_B   = 64;
  localparam int IW    = 1;
  localparam int TMO   = 200;
  localparam int RN    = 20;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req_in;
  logic [N_REQ*N_K-1:0] k_in;
  logic [N_REQ*N_B-1:0] m_in;
  logic [N_REQ-1:0]     ack_out;
  logic [N_B-1:0]       c_out;
  logic                 busy;
  logic [IW-1:0]        grant;
  logic [N_K-1:0]       core_k;
  logic [N_B-1:0]       core_m;
  logic                 core_req;
  logic [N_B-1:0]       core_c;
  logic                 core_ack;

  logic        req_d [N_REQ];
  logic [63:0] k_d   [N_REQ];
  logic [63:0] m_d   [N_REQ];

  assign req_in = {req_d[1], req_d[0]};
  assign k_in   = {k_d[1], k_d[0]};
  assign m_in   = {m_d[1], m_d[0]};

  encrypt_arbiter #(.N_REQ(N_REQ), .N_K(N_K), .N_B(N_B)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .k_in     (k_in),
    .m_in     (m_in),
    .ack_out  (ack_out),
    .c_out    (c_out),
    .busy     (busy),
    .grant    (grant),
    .core_k   (core_k),
    .core_m   (core_m),
    .core_req (core_req),
    .core_c   (core_c),
    .core_ack (core_ack)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int          n_cmp;
  int          n_bad;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  int          served_q[$];
  int          model_ptr;
  int          wait_cnt [N_REQ];

  function automatic logic [63:0] cipher(input logic [63:0] k, input logic [63:0] m);
    logic [63:0] x;
    x = m ^ k;
    x = {x[50:0], x[63:51]} + (k * 64'h9E3779B97F4A7C15);
    return x ^ {k[31:0], k[63:32]};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Round-robin reference: first set bit of pend at or after p, wrapping.
  function automatic int rr_pick(input logic [N_REQ-1:0] pend, input int p);
    int idx;
    for (int j = 0; j < N_REQ; j++) begin
      idx = (p + j) % N_REQ;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  task automatic push_exp(input int i, input logic [63:0] v);
    if (i == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic drop_last(input int i);
    if (i == 0 && exp_q0.size() != 0) void'(exp_q0.pop_back());
    if (i == 1 && exp_q1.size() != 0) void'(exp_q1.pop_back());
  endtask

  // ---------------- core stand-in ----------------
  logic       core_ack_r;
  logic       stale_ack;
  logic [1:0] core_cnt;
  logic [1:0] core_lat;

  assign core_ack = core_ack_r | stale_ack;

  // 4-phase responder: ack after 1..4 cycles, ack falls one cycle after req.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_ack_r <= 1'b0;
      core_cnt   <= 2'd0;
      core_lat   <= 2'd0;
      core_c     <= '0;
    end else if (core_req && !core_ack_r) begin
      if (core_cnt >= core_lat) begin
        core_ack_r <= 1'b1;
        core_c     <= cipher(core_k, core_m);
        core_cnt   <= 2'd0;
        core_lat   <= 2'($urandom_range(0, 3));
      end else begin
        core_cnt <= core_cnt + 2'd1;
      end
    end else if (!core_req && core_ack_r) begin
      core_ack_r <= 1'b0;
    end
  end

  // ---------------- requester driver ----------------
  task automatic do_req(input int i, input bit sync, input logic [63:0] k, input logic [63:0] m);
    int t;
    if (sync) @(negedge clk);
    k_d[i]   = k;
    m_d[i]   = m;
    req_d[i] = 1'b1;
    push_exp(i, cipher(k, m));
    t = 0;
    while (ack_out[i] !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    if (ack_out[i] !== 1'b1) begin
      fail_now($sformatf("ack_rise_timeout_req%0d", i));
      drop_last(i);
    end
    req_d[i] = 1'b0;
    t = 0;
    while (ack_out[i] !== 1'b0 && t < TMO) begin @(negedge clk); t++; end
    if (ack_out[i] !== 1'b0) fail_now($sformatf("ack_fall_timeout_req%0d", i));
  endtask

  task automatic both_rr(input string name);
    int first;
    int second;
    first  = rr_pick(2'b11, model_ptr);
    second = rr_pick(2'b11 & ~(2'b01 << first), (first + 1) % N_REQ);
    served_q.delete();
    fork
      do_req(0, 1'b1, rnd64(), rnd64());
      do_req(1, 1'b1, rnd64(), rnd64());
    join
    check({name, "_count"}, served_q.size(), 2);
    if (served_q.size() == 2) begin
      check({name, "_first"},  served_q[0], first);
      check({name, "_second"}, served_q[1], second);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    served_q.delete();
  endtask

  // ---------------- monitor ----------------
  logic [N_REQ-1:0] prev_ack;
  logic [63:0]      held_c;
  logic [63:0]      e;

  initial begin
    prev_ack = '0;
    held_c   = '0;
    for (int j = 0; j < N_REQ; j++) wait_cnt[j] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ack = '0;
        continue;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (ack_out[i] && !prev_ack[i]) begin
          check($sformatf("ack_onehot_%0d", i), $countones(ack_out), 1);
          check($sformatf("ack_grant_%0d", i), 64'(grant), 64'(i));
          if (i == 0) begin
            if (exp_q0.size() == 0) fail_now("unexpected_ack_req0");
            else begin e = exp_q0.pop_front(); check("c_out_req0", c_out, e); end
          end else begin
            if (exp_q1.size() == 0) fail_now("unexpected_ack_req1");
            else begin e = exp_q1.pop_front(); check("c_out_req1", c_out, e); end
          end
          held_c = c_out;
          served_q.push_back(i);
          model_ptr = (i + 1) % N_REQ;
          for (int j = 0; j < N_REQ; j++) begin
            if (j != i && req_in[j]) begin
              wait_cnt[j]++;
              check($sformatf("fair_wait_req%0d", j), 64'(wait_cnt[j] <= N_REQ - 1), 64'(1));
            end
          end
          wait_cnt[i] = 0;
        end else if (ack_out[i]) begin
          check($sformatf("c_stable_req%0d", i), c_out, held_c);
        end
      end
      for (int j = 0; j < N_REQ; j++) if (!req_in[j]) wait_cnt[j] = 0;
      prev_ack = ack_out;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] M1 = 64'h0123456789ABCDEF;

  int          t;
  int          e0, e1, e2;
  int          winner;
  logic        saw_ack;
  logic [63:0] k6, m6;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_ptr = 0;
    stale_ack = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      req_d[i] = 1'b0;
      k_d[i]   = '0;
      m_d[i]   = '0;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack_out",  64'(ack_out), 0);
    check("rst_c_out",    c_out, 0);
    check("rst_busy",     64'(busy), 0);
    check("rst_grant",    64'(grant), 0);
    check("rst_core_k",   core_k, 0);
    check("rst_core_m",   core_m, 0);
    check("rst_core_req", 64'(core_req), 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: single operation; grant takes one cycle and latches operands
    served_q.delete();
    fork
      do_req(0, 1'b1, K1, M1);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t1_core_req", 64'(core_req), 1);
        check("t1_core_k",   core_k, K1);
        check("t1_core_m",   core_m, M1);
        check("t1_busy",     64'(busy), 1);
        check("t1_grant",    64'(grant), 0);
      end
    join
    check("t1_served", served_q.size(), 1);

    // T2: simultaneous requests after reset, then again to confirm ptr wrapped
    apply_reset();
    both_rr("t2");
    both_rr("t2b");

    // T3: requester 0 re-requests the moment its ack falls while 1 is pending
    served_q.delete();
    e0 = rr_pick(2'b01, model_ptr);
    e1 = rr_pick(2'b11, (e0 + 1) % N_REQ);
    e2 = rr_pick(2'b01, (e1 + 1) % N_REQ);
    fork
      begin
        do_req(0, 1'b1, rnd64(), rnd64());
        do_req(0, 1'b0, rnd64(), rnd64());
      end
      begin
        t = 0;
        while (!busy && t < TMO) begin @(negedge clk); t++; end
        do_req(1, 1'b1, rnd64(), rnd64());
      end
    join
    check("t3_count", served_q.size(), 3);
    if (served_q.size() == 3) begin
      check("t3_first",  served_q[0], e0);
      check("t3_second", served_q[1], e1);
      check("t3_third",  served_q[2], e2);
    end

    // T4: requester 1 aborts during ISSUE; no ack, ptr still advances
    winner = rr_pick(2'b10, model_ptr);
    @(negedge clk);
    k_d[1] = rnd64();
    m_d[1] = rnd64();
    req_d[1] = 1'b1;
    t = 0;
    while (core_req !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    check("t4_core_req_seen", 64'(core_req), 1);
    req_d[1] = 1'b0;
    saw_ack = 1'b0;
    t = 0;
    while (core_ack !== 1'b1 && t < TMO) begin @(negedge clk); t++; saw_ack |= |ack_out; end
    check("t4_core_ack_seen", 64'(core_ack), 1);
    t = 0;
    while (busy !== 1'b0 && t < TMO) begin @(negedge clk); t++; saw_ack |= |ack_out; end
    check("t4_busy_clear", 64'(busy), 0);
    check("t4_no_ack", 64'(saw_ack | (|ack_out)), 0);
    model_ptr = (winner + 1) % N_REQ;
    both_rr("t4_ptr");

    // Stale core_ack in IDLE blocks a new grant until it clears
    @(negedge clk);
    stale_ack = 1'b1;
    fork
      do_req(0, 1'b1, rnd64(), rnd64());
      begin
        repeat (4) begin
          @(negedge clk);
          check("stale_no_grant", 64'(core_req), 0);
          check("stale_idle",     64'(busy), 0);
        end
        stale_ack = 1'b0;
      end
    join

    // T6: operands changed after grant have no effect
    k6 = rnd64();
    m6 = rnd64();
    fork
      do_req(0, 1'b1, k6, m6);
      begin
        t = 0;
        while (core_req !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
        m_d[0] = ~m6;
        k_d[0] = ~k6;
        @(negedge clk);
        check("t6_core_m_held", core_m, m6);
        check("t6_core_k_held", core_k, k6);
      end
    join

    // T5: asynchronous reset while in ISSUE clears everything at once
    @(negedge clk);
    k_d[0] = rnd64();
    m_d[0] = rnd64();
    req_d[0] = 1'b1;
    t = 0;
    while (core_req !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    check("t5_in_issue", 64'(core_req), 1);
    #1 rst = 1'b1;
    #1;
    check("t5_ack_out",  64'(ack_out), 0);
    check("t5_c_out",    c_out, 0);
    check("t5_busy",     64'(busy), 0);
    check("t5_grant",    64'(grant), 0);
    check("t5_core_k",   core_k, 0);
    check("t5_core_m",   core_m, 0);
    check("t5_core_req", 64'(core_req), 0);
    req_d[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    served_q.delete();
    do_req(0, 1'b1, K1, M1);
    check("t5_fresh_served", served_q.size(), 1);

    // Randomised traffic from both requesters
    fork
      for (int n = 0; n < RN; n++) begin
        int d0;
        d0 = $urandom_range(0, 3);
        if (d0 == 0) do_req(0, 1'b0, rnd64(), rnd64());
        else begin
          repeat (d0 - 1) @(negedge clk);
          do_req(0, 1'b1, rnd64(), rnd64());
        end
      end
      for (int n = 0; n < RN; n++) begin
        int d1;
        d1 = $urandom_range(0, 3);
        if (d1 == 0) do_req(1, 1'b0, rnd64(), rnd64());
        else begin
          repeat (d1 - 1) @(negedge clk);
          do_req(1, 1'b1, rnd64(), rnd64());
        end
      end
    join

    repeat (3) @(negedge clk);
    check("final_exp_q0_empty", exp_q0.size(), 0);
    check("final_exp_q1_empty", exp_q1.size(), 0);
    check("final_idle", 64'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
